// File: rtl/lpc_post_capture_if.sv
// Register-access bundle between the LPC decoder and the POST-code capture block.
// The master side is the decoder (or a bench); the slave side is lpc_post_capture.
interface lpc_post_capture_if;
    logic [7:0] AddrReg;
    logic       Wr;
    logic       Rd;
    logic [7:0] DataWr;
    logic [7:0] RdData;
    logic [7:0] DispCode;
    logic       DispValid;
    logic       Overflow;

    modport master (
        output AddrReg, Wr, Rd, DataWr,
        input  RdData, DispCode, DispValid, Overflow
    );

    modport slave (
        input  AddrReg, Wr, Rd, DataWr,
        output RdData, DispCode, DispValid, Overflow
    );
endinterface

// File: rtl/lpc_post_capture.sv
// BIOS POST-code capture: an 8-deep FIFO readable over LPC plus a display path
// that holds each shown code for a minimum time, always jumping to the newest.
module lpc_post_capture #(
    parameter logic [7:0]  POST_ADDR   = 8'h20,
    parameter logic [7:0]  STAT_ADDR   = 8'h21,
    parameter int unsigned HOLD_CYCLES = 33_000_000
) (
    input logic                LpcClock,
    input logic                PciReset,
    lpc_post_capture_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHOW, SHOW_PEND} disp_state_e;

    localparam logic [24:0] HOLD_LAST = 25'(HOLD_CYCLES - 1);

    logic        wr_q, rd_q, arm_q;
    logic        wr_evt, rd_end, push, pop, stat_wr, flush, clr_ovf, full;
    logic [2:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [8];
    logic [7:0]  rd_data;
    disp_state_e state_q, state_d;
    logic [24:0] timer_q, timer_d;
    logic [7:0]  disp_q, disp_d, pend_q, pend_d;
    logic        expired;

    // arm_q blocks the first edge after reset so a strobe already high at release is ignored.
    assign wr_evt  = arm_q & bus.Wr & ~wr_q;
    assign rd_end  = ~bus.Rd & rd_q;
    assign full    = (count_q == 4'd8);
    assign push    = wr_evt && (bus.AddrReg == POST_ADDR);
    assign pop     = rd_end && (bus.AddrReg == POST_ADDR) && (count_q != 4'd0);
    assign stat_wr = wr_evt && (bus.AddrReg == STAT_ADDR);
    assign flush   = stat_wr & bus.DataWr[1];
    assign clr_ovf = stat_wr & bus.DataWr[0];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            arm_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= bus.Wr;
            rd_q    <= bus.Rd;
            arm_q   <= 1'b1;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge LpcClock) begin
        if (push) begin
            mem_q[wptr_q] <= bus.DataWr;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + 3'd1;
            end
            // A push into a full FIFO drops the oldest entry.
            if (pop || (push && full)) begin
                rptr_d = rptr_q + 3'd1;
            end
            if (push && !pop && !full) begin
                count_d = count_q + 4'd1;
            end else if (pop && !push) begin
                count_d = count_q - 4'd1;
            end
            if (push && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (bus.AddrReg == POST_ADDR) begin
            rd_data = (count_q != 4'd0) ? mem_q[rptr_q] : 8'hFF;
        end else if (bus.AddrReg == STAT_ADDR) begin
            rd_data = {ovf_q, 3'b000, count_q};
        end
    end

    assign expired = (timer_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        disp_d  = disp_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (push) begin
                    disp_d  = bus.DataWr;
                    timer_d = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (push && expired) begin
                    disp_d  = bus.DataWr;
                    timer_d = '0;
                end else begin
                    if (!expired) begin
                        timer_d = timer_q + 25'd1;
                    end
                    if (push) begin
                        pend_d  = bus.DataWr;
                        state_d = SHOW_PEND;
                    end
                end
            end
            SHOW_PEND: begin
                if (expired) begin
                    // A push landing on the expiry cycle is the newest code, so show it.
                    disp_d  = push ? bus.DataWr : pend_q;
                    timer_d = '0;
                    state_d = SHOW;
                end else begin
                    timer_d = timer_q + 25'd1;
                    if (push) begin
                        pend_d = bus.DataWr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q <= IDLE;
            timer_q <= '0;
            disp_q  <= 8'h00;
            pend_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.RdData    = rd_data;
    assign bus.DispCode  = disp_q;
    assign bus.DispValid = (state_q != IDLE);
    assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_lpc_post_capture.sv
// Bench for lpc_post_capture: vector table for FIFO/read-mux behaviour, scoreboard
// queue for read data, and hand sequences for display hold, collisions and reset.
module tb_lpc_post_capture;
    localparam logic [7:0] POST = 8'h20;
    localparam logic [7:0] STAT = 8'h21;
    localparam int         HOLD = 16;

    typedef enum logic {OP_WR, OP_RD} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] addr;
        logic [7:0] data;
        int         len;
        logic [7:0] exp_rd;
        logic [7:0] exp_stat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #15 clk = ~clk;

    lpc_post_capture_if bus ();

    lpc_post_capture #(
        .POST_ADDR   (POST),
        .STAT_ADDR   (STAT),
        .HOLD_CYCLES (HOLD)
    ) dut (
        .LpcClock (clk),
        .PciReset (rst_n),
        .bus      (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb_q[$];
    logic       ovf_m = 1'b0;
    vec_t       vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_stat();
        return {ovf_m, 3'b000, 4'(sb_q.size())};
    endfunction

    function automatic logic [7:0] m_head();
        return (sb_q.size() > 0) ? sb_q[0] : 8'hFF;
    endfunction

    function automatic void m_push(input logic [7:0] d);
        if (sb_q.size() == 8) begin
            void'(sb_q.pop_front());
            ovf_m = 1'b1;
        end
        sb_q.push_back(d);
    endfunction

    function automatic void m_stat_wr(input logic [7:0] d);
        if (d[0]) ovf_m = 1'b0;
        if (d[1]) sb_q.delete();
    endfunction

    task automatic do_reset();
        bus.Wr = 1'b0;
        bus.Rd = 1'b0;
        bus.AddrReg = 8'h00;
        bus.DataWr = 8'h00;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        sb_q.delete();
        ovf_m = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input int len);
        bus.AddrReg = addr;
        bus.DataWr = data;
        bus.Wr = 1'b1;
        repeat (len) tick();
        bus.Wr = 1'b0;
        tick();
        if (addr == POST) m_push(data);
        else if (addr == STAT) m_stat_wr(data);
    endtask

    task automatic do_read(input logic [7:0] addr, output logic [7:0] data, output logic [7:0] exp);
        bus.AddrReg = addr;
        bus.Rd = 1'b1;
        exp = (addr == POST) ? m_head() : (addr == STAT) ? m_stat() : 8'h00;
        tick();
        data = bus.RdData;
        bus.Rd = 1'b0;
        tick();
        if (addr == POST && sb_q.size() > 0) void'(sb_q.pop_front());
    endtask

    task automatic check_stat(input string name, input logic [7:0] exp);
        bus.AddrReg = STAT;
        #1;
        check(name, bus.RdData, exp);
    endtask

    initial begin
        logic [7:0] rd, exp;

        for (int i = 1; i <= 9; i++)
            vecs.push_back('{OP_WR, POST, 8'(i), 1 + (i % 3), 8'h00, (i < 9) ? 8'(i) : 8'h88});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{OP_RD, POST, 8'h00, 1, 8'(i + 2), 8'h80 | 8'(7 - i)});
        vecs.push_back('{OP_RD, POST, 8'h00, 1, 8'hFF, 8'h80});
        vecs.push_back('{OP_WR, STAT, 8'h01, 2, 8'h00, 8'h00});
        vecs.push_back('{OP_WR, 8'h30, 8'h44, 1, 8'h00, 8'h00});
        vecs.push_back('{OP_RD, 8'h30, 8'h00, 1, 8'h00, 8'h00});
        vecs.push_back('{OP_WR, POST, 8'h5A, 1, 8'h00, 8'h01});
        vecs.push_back('{OP_WR, STAT, 8'h02, 3, 8'h00, 8'h00});
        vecs.push_back('{OP_RD, POST, 8'h00, 1, 8'hFF, 8'h00});

        // Reset state and the single long write strobe.
        do_reset();
        check("reset_dispvalid", bus.DispValid, 1'b0);
        check("reset_dispcode", bus.DispCode, 8'h00);
        check("reset_overflow", bus.Overflow, 1'b0);
        check_stat("reset_stat", 8'h00);
        bus.AddrReg = POST;
        #1;
        check("reset_empty_read", bus.RdData, 8'hFF);

        bus.AddrReg = POST;
        bus.DataWr = 8'hA5;
        bus.Wr = 1'b1;
        tick();
        check("wr3_dispcode", bus.DispCode, 8'hA5);
        check("wr3_dispvalid", bus.DispValid, 1'b1);
        repeat (2) tick();
        bus.Wr = 1'b0;
        tick();
        m_push(8'hA5);
        check_stat("wr3_stat", 8'h01);
        check("wr3_stat_model", bus.RdData, m_stat());

        // Table-driven FIFO and read-mux vectors.
        do_reset();
        foreach (vecs[i]) begin
            if (vecs[i].op == OP_WR) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].len);
            end else begin
                do_read(vecs[i].addr, rd, exp);
                check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
                check($sformatf("vec%0d_sb", i), rd, exp);
            end
            check_stat($sformatf("vec%0d_stat", i), vecs[i].exp_stat);
            check($sformatf("vec%0d_ovf", i), bus.Overflow, vecs[i].exp_stat[7]);
        end

        // Display hold: newest pending code wins, direct load after saturation.
        do_reset();
        bus.AddrReg = POST;
        for (int c = 0; c <= 45; c++) begin
            bus.Wr = 1'b1;
            unique case (c)
                0:  bus.DataWr = 8'h10;
                3:  bus.DataWr = 8'h11;
                5:  bus.DataWr = 8'h12;
                40: bus.DataWr = 8'h13;
                42: bus.DataWr = 8'h14;
                default: bus.Wr = 1'b0;
            endcase
            tick();
            exp = (c < 16) ? 8'h10 : (c < 40) ? 8'h12 : 8'h13;
            check($sformatf("hold_c%0d", c), bus.DispCode, exp);
        end
        bus.Wr = 1'b0;
        check("hold_valid", bus.DispValid, 1'b1);

        // Pop and push in the same cycle on a full FIFO.
        do_reset();
        for (int i = 0; i < 8; i++) do_write(POST, 8'h30 + 8'(i), 1);
        bus.AddrReg = POST;
        bus.Rd = 1'b1;
        tick();
        check("coll_head", bus.RdData, m_head());
        bus.Rd = 1'b0;
        bus.DataWr = 8'hAA;
        bus.Wr = 1'b1;
        tick();
        void'(sb_q.pop_front());
        sb_q.push_back(8'hAA);
        bus.Wr = 1'b0;
        tick();
        check_stat("coll_stat", 8'h08);
        check("coll_ovf", bus.Overflow, 1'b0);
        bus.AddrReg = POST;
        #1;
        check("coll_newhead", bus.RdData, 8'h31);
        for (int i = 0; i < 8; i++) begin
            do_read(POST, rd, exp);
            check($sformatf("coll_drain%0d", i), rd, exp);
        end
        check_stat("coll_drained", 8'h00);

        // Clear overflow and flush together; display keeps its code.
        do_reset();
        for (int i = 1; i <= 9; i++) do_write(POST, 8'(i), 1);
        repeat (40) tick();
        check_stat("ovf_full_stat", 8'h88);
        check("ovf_dispcode", bus.DispCode, 8'h09);
        do_write(STAT, 8'h03, 1);
        check_stat("clr_flush_stat", 8'h00);
        check("clr_flush_model", bus.RdData, m_stat());
        check("clr_flush_dispcode", bus.DispCode, 8'h09);
        check("clr_flush_ovf", bus.Overflow, 1'b0);

        // Reset during SHOW_PEND with the write strobe held high across release.
        do_reset();
        do_write(POST, 8'h10, 1);
        do_write(POST, 8'h11, 1);
        bus.AddrReg = POST;
        bus.DataWr = 8'h77;
        bus.Wr = 1'b1;
        tick();
        #5;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", bus.DispValid, 1'b0);
        check("rst_async_empty", bus.RdData, 8'hFF);
        repeat (2) tick();
        rst_n = 1'b1;
        sb_q.delete();
        ovf_m = 1'b0;
        tick();
        check("rst_rel_empty", bus.RdData, 8'hFF);
        check("rst_rel_valid", bus.DispValid, 1'b0);
        repeat (3) tick();
        check("rst_hold_empty", bus.RdData, 8'hFF);
        bus.Wr = 1'b0;
        tick();
        bus.Wr = 1'b1;
        tick();
        m_push(8'h77);
        check("rst_after_push", bus.RdData, m_head());
        check("rst_after_disp", bus.DispCode, 8'h77);
        check("rst_after_valid", bus.DispValid, 1'b1);
        bus.Wr = 1'b0;
        tick();
        check_stat("rst_after_stat", 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
